// File: rtl/regxfer_seq_pkg.sv
// regxfer_seq_pkg: command codes and FSM state encodings shared by the sequencer and its bench.
package regxfer_seq_pkg;
    typedef enum logic [1:0] {
        CMD_MOVE  = 2'b00,
        CMD_STORE = 2'b01,
        CMD_LOAD  = 2'b10,
        CMD_ILL   = 2'b11
    } cmd_e;
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MV   = 3'd1;
    localparam logic [2:0] S_MAR  = 3'd2;
    localparam logic [2:0] S_MDR  = 3'd3;
    localparam logic [2:0] S_WR   = 3'd4;
    localparam logic [2:0] S_RDW  = 3'd5;
    localparam logic [2:0] S_WB   = 3'd6;
    localparam logic [2:0] S_DONE = 3'd7;
endpackage

// File: rtl/regxfer_seq_waitcnt.sv
// seq_waitcnt: loadable 3-bit down-counter with zero flag; holds at zero instead of wrapping.
module seq_waitcnt (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic [2:0] val_i,
    input  logic       dec_i,
    output logic       zero_o
);
    logic [2:0] cnt_q, cnt_d;
    always_comb cnt_d = load_i ? val_i : (dec_i && cnt_q != 3'd0) ? cnt_q - 3'd1 : cnt_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    assign zero_o = cnt_q == 3'd0;
endmodule

// File: rtl/regxfer_seq.sv
// regxfer_seq: sequences register move/store/load transfers on the shared bus; all strobes are
// decoded from the registered state so an async reset drops them in the same instant.
module regxfer_seq
    import regxfer_seq_pkg::*;
#(
    parameter int RD_WAIT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] cmd,
    input  logic [2:0] rs,
    input  logic [2:0] rd,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [2:0] rsel,
    output logic [2:0] wsel,
    output logic       wrr,
    output logic       mar_l,
    output logic       mdr_l,
    output logic       mem_t,
    output logic       mrw
);
    localparam logic [2:0] WAIT_INIT = (RD_WAIT > 0) ? 3'(RD_WAIT - 1) : 3'd0;
    logic [2:0] state_q, state_d, rs_q, rd_q;
    cmd_e       cmd_q;
    logic       accept, wait_zero;
    assign accept = state_q == S_IDLE && start;
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:           if (start) state_d = cmd == CMD_MOVE ? S_MV : cmd == CMD_ILL ? S_DONE : S_MAR;
            S_MV, S_WR, S_WB: state_d = S_DONE;
            S_MAR:            state_d = cmd_q == CMD_STORE ? S_MDR : RD_WAIT == 0 ? S_WB : S_RDW;
            S_MDR:            state_d = S_WR;
            S_RDW:            state_d = wait_zero ? S_WB : S_RDW;
            default:          state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state_q <= S_IDLE;
            cmd_q   <= CMD_MOVE;
            rs_q    <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cmd_q <= cmd_e'(cmd);
                rs_q  <= rs;
                rd_q  <= rd;
            end
        end
    seq_waitcnt u_wait (
        .clk   (clk),
        .rst_n (reset),
        .load_i(state_q == S_MAR && state_d == S_RDW),
        .val_i (WAIT_INIT),
        .dec_i (state_q == S_RDW),
        .zero_o(wait_zero)
    );
    assign busy  = state_q != S_IDLE;
    assign done  = state_q == S_DONE;
    assign err   = done && cmd_q == CMD_ILL;
    assign rsel  = busy ? rs_q : 3'd0;
    assign wsel  = busy ? rd_q : 3'd0;
    assign wrr   = state_q == S_MV || state_q == S_WB;
    assign mar_l = state_q == S_MAR;
    assign mdr_l = state_q == S_MDR;
    assign mem_t = state_q == S_WB;
    assign mrw   = state_q == S_WR;
endmodule
